pixel_gain: RTL

Parametrised per-channel pixel gain stage: successor to the single-channel saturation adjuster in the D8M live-video path. It scales any subset of the packed colour channels by a shared user level, saturating at full scale. Two-stage pipeline with valid and an aligned pass-through bus. Sits between the camera RGB unpacker and the VGA output mux; inc/dec come from the debounced push-button block.

---
 rtl/pixel_gain_if.sv | 34 +++
 rtl/pixel_gain.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pixel_gain_if.sv
// pixel_gain_if
//   Pixel stream bundle around the gain stage: input beat (valid, packed
//   pixel, side data) and the matching output beat two cycles later.
//
//   Handshake: valid-only streaming, with no ready/backpressure. Data moves
//   on every rising clk edge whether or not valid is high. A beat is
//   meaningful only in a cycle where its valid is 1. The consumer must
//   accept every valid beat in the cycle it is presented.
//
//   Modports:
//     master - stream source/sink side (drives *_in, observes *_out)
//     slave  - the gain stage (observes *_in, drives *_out)
interface pixel_gain_if #(
  parameter int CH_W   = 8,
  parameter int NUM_CH = 3,
  parameter int PASS_W = 24
);
  logic                     valid_in;
  logic [NUM_CH*CH_W-1:0]   pixel_in;
  logic [PASS_W-1:0]        pass_in;
  logic                     valid_out;
  logic [NUM_CH*CH_W-1:0]   pixel_out;
  logic [PASS_W-1:0]        pass_out;

  modport master (
    output valid_in, pixel_in, pass_in,
    input  valid_out, pixel_out, pass_out
  );

  modport slave (
    input  valid_in, pixel_in, pass_in,
    output valid_out, pixel_out, pass_out
  );
endinterface

// File: rtl/pixel_gain.sv
// pixel_gain
//   Per-channel pixel gain stage. Channels selected by CH_MASK are multiplied
//   by a shared level (fixed point, FRAC fractional bits, unity = 2^FRAC) and
//   saturated at full scale. Other channels pass through unchanged. The
//   pipeline has two stages, never stalls, and carries a side bus aligned to
//   the pixel.
//
//   Optional build macro: PIXEL_GAIN_ROUND_EN
//     defined   -> round half up before saturation (adds 2^(FRAC-1))
//     undefined -> truncate
//
//   Ports:
//     clk       pixel clock, rising edge
//     rst       asynchronous active-low reset
//     inc, dec  level up/down; only the rising edge of each input acts
//     lvl_clr   synchronous return of the level to unity (highest priority)
//     bus       pixel_gain_if.slave: valid_in/pixel_in/pass_in in,
//               valid_out/pixel_out/pass_out out, 2-cycle latency
//     level_out current gain level
module pixel_gain #(
  parameter int                CH_W    = 8,
  parameter int                NUM_CH  = 3,
  parameter int                LVL_W   = 4,
  parameter int                FRAC    = 3,
  parameter logic [NUM_CH-1:0] CH_MASK = 3'b010,
  parameter int                PASS_W  = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             lvl_clr,
  pixel_gain_if.slave      bus,
  output logic [LVL_W-1:0] level_out
);

  localparam int P_W = CH_W + LVL_W;  // full product width
  localparam int S_W = P_W + 1;       // room for the rounding carry

  localparam logic [LVL_W-1:0] UNITY   = LVL_W'(2 ** FRAC);
  localparam logic [LVL_W-1:0] LVL_MAX = '1;
  localparam logic [S_W-1:0]   CH_MAX  = S_W'(2 ** CH_W - 1);
`ifdef PIXEL_GAIN_ROUND_EN
  localparam logic [S_W-1:0]   RND     = S_W'(2 ** (FRAC - 1));
`else
  localparam logic [S_W-1:0]   RND     = '0;
`endif

  // Level control.
  logic inc_q, dec_q;
  logic inc_rise, dec_rise;

  assign inc_rise = inc & ~inc_q;
  assign dec_rise = dec & ~dec_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      level_out <= UNITY;
    end else begin
      inc_q <= inc;
      dec_q <= dec;
      if (lvl_clr) begin
        level_out <= UNITY;
      end else if (inc_rise && dec_rise) begin
        level_out <= level_out;  // opposing edges cancel
      end else if (inc_rise && level_out != LVL_MAX) begin
        level_out <= level_out + 1'b1;
      end else if (dec_rise && level_out != '0) begin
        level_out <= level_out - 1'b1;
      end
    end
  end

  // Stage 1: masked channels hold the raw product. Unmasked channels hold a
  // zero-extended copy, so both kinds share one register array.
  logic [P_W-1:0]    s1_ch_d [NUM_CH];
  logic [P_W-1:0]    s1_ch   [NUM_CH];
  logic              s1_valid;
  logic [PASS_W-1:0] s1_pass;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      s1_ch_d[i] = P_W'(bus.pixel_in[i*CH_W +: CH_W]);
      if (CH_MASK[i]) begin
        s1_ch_d[i] = P_W'(bus.pixel_in[i*CH_W +: CH_W]) * P_W'(level_out);
      end
    end
  end

  // Stage 2: round (or truncate), drop the fraction, then clamp to full scale.
  logic [S_W-1:0]           rnd_sum [NUM_CH];
  logic [S_W-1:0]           shifted [NUM_CH];
  logic [NUM_CH*CH_W-1:0]   s2_pix_d;
  logic [NUM_CH*CH_W-1:0]   s2_pix;
  logic                     s2_valid;
  logic [PASS_W-1:0]        s2_pass;

  always_comb begin
    s2_pix_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rnd_sum[i] = S_W'(s1_ch[i]) + RND;
      shifted[i] = rnd_sum[i] >> FRAC;
      if (!CH_MASK[i]) begin
        s2_pix_d[i*CH_W +: CH_W] = s1_ch[i][CH_W-1:0];
      end else if (shifted[i] > CH_MAX) begin
        s2_pix_d[i*CH_W +: CH_W] = CH_MAX[CH_W-1:0];
      end else begin
        s2_pix_d[i*CH_W +: CH_W] = shifted[i][CH_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1_ch[i] <= '0;
      end
      s1_valid <= 1'b0;
      s1_pass  <= '0;
      s2_pix   <= '0;
      s2_valid <= 1'b0;
      s2_pass  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        s1_ch[i] <= s1_ch_d[i];
      end
      s1_valid <= bus.valid_in;
      s1_pass  <= bus.pass_in;
      s2_pix   <= s2_pix_d;
      s2_valid <= s1_valid;
      s2_pass  <= s1_pass;
    end
  end

  assign bus.valid_out = s2_valid;
  assign bus.pixel_out = s2_pix;
  assign bus.pass_out  = s2_pass;

endmodule
